// File: rtl/bin_to_bcd_seq.sv
// Sequential 8-bit binary to 3-digit BCD converter (double dabble, one bit per clock).
// Also produces leading-zero blanking flags for the display scanner.
//
//   state   | meaning
//   --------+----------------------------------------------------------
//   S_IDLE  | waiting for start; digit outputs hold the last result
//   S_SHIFT | one add-3/shift iteration per clock, 8 iterations total
module bin_to_bcd_seq #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] bin,
    output logic         busy,
    output logic         done,
    output logic [3:0]   cen,
    output logic [3:0]   dec,
    output logic [3:0]   uni,
    output logic [1:0]   blank
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   sh_q, sh_d;
    logic [11:0]    bcd_q, bcd_d;
    logic [2:0]     cnt_q, cnt_d;
    logic [3:0]     cen_q, cen_d;
    logic [3:0]     dec_q, dec_d;
    logic [3:0]     uni_q, uni_d;
    logic [1:0]     blank_q, blank_d;
    logic           done_q, done_d;

    logic           load;
    logic           last;
    logic [11:0]    adj;
    logic [W+11:0]  cat;
    logic [11:0]    bcd_sh;
    logic [W-1:0]   sh_sh;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start)         state_d = S_SHIFT;
            S_SHIFT: if (cnt_q == 3'd7) state_d = S_IDLE;
            default:                    state_d = S_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        busy = (state_q == S_SHIFT);
        load = (state_q == S_IDLE) && start;
        last = (state_q == S_SHIFT) && (cnt_q == 3'd7);
    end

    // One double-dabble step: correct nibbles >= 5, then shift the whole chain left
    always_comb begin
        adj = bcd_q;
        for (int i = 0; i < 3; i++) begin
            if (adj[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
            end
        end
        cat    = {adj, sh_q} << 1;
        bcd_sh = cat[W+11:W];
        sh_sh  = cat[W-1:0];
    end

    always_comb begin
        sh_d    = sh_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        cen_d   = cen_q;
        dec_d   = dec_q;
        uni_d   = uni_q;
        blank_d = blank_q;
        done_d  = 1'b0;
        if (load) begin
            sh_d  = bin;
            bcd_d = 12'd0;
            cnt_d = 3'd0;
        end else if (busy) begin
            sh_d  = sh_sh;
            bcd_d = bcd_sh;
            cnt_d = cnt_q + 3'd1;
        end
        // Results become visible only once the eighth shift lands
        if (last) begin
            cen_d   = bcd_sh[11:8];
            dec_d   = bcd_sh[7:4];
            uni_d   = bcd_sh[3:0];
            blank_d = {(bcd_sh[11:8] == 4'd0),
                       (bcd_sh[11:8] == 4'd0) && (bcd_sh[7:4] == 4'd0)};
            done_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_q    <= '0;
            bcd_q   <= 12'd0;
            cnt_q   <= 3'd0;
            cen_q   <= 4'd0;
            dec_q   <= 4'd0;
            uni_q   <= 4'd0;
            blank_q <= 2'b11;
            done_q  <= 1'b0;
        end else begin
            sh_q    <= sh_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            cen_q   <= cen_d;
            dec_q   <= dec_d;
            uni_q   <= uni_d;
            blank_q <= blank_d;
            done_q  <= done_d;
        end
    end

    assign done  = done_q;
    assign cen   = cen_q;
    assign dec   = dec_q;
    assign uni   = uni_q;
    assign blank = blank_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed bench for bin_to_bcd_seq: reset, latency, blanking, back-to-back sweep,
// ignored start while busy and mid-conversion reset.
module tb_bin_to_bcd_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] bin;
    logic       busy;
    logic       done;
    logic [3:0] cen;
    logic [3:0] dec;
    logic [3:0] uni;
    logic [1:0] blank;

    int total = 0;
    int bad   = 0;

    bin_to_bcd_seq #(.W(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .cen   (cen),
        .dec   (dec),
        .uni   (uni),
        .blank (blank)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1, "watchdog expired");
    end

    // Raise start for exactly one rising edge; returns at the first falling edge after it.
    task automatic pulse_start(input logic [7:0] v);
        @(negedge clk);
        start = 1'b1;
        bin   = v;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Runs one conversion and observes it; returns one cycle after the done cycle.
    task automatic convert(input logic [7:0] v, output int busy_cnt, output int early_done,
                           output logic held, output logic done8, output logic done9);
        logic [13:0] prev;
        prev       = {cen, dec, uni, blank};
        held       = 1'b1;
        busy_cnt   = 0;
        early_done = 0;
        pulse_start(v);
        for (int k = 0; k < 8; k++) begin
            if (busy === 1'b1) busy_cnt++;
            if (done === 1'b1) early_done++;
            if ({cen, dec, uni, blank} !== prev) held = 1'b0;
            @(negedge clk);
        end
        done8 = done;
        @(negedge clk);
        done9 = done;
    endtask

    task automatic test_reset;
        rst   = 1'b1;
        start = 1'b0;
        bin   = 8'd0;
        #3;
        total++;
        if (busy !== 1'b0 || done !== 1'b0)
            begin bad++; $display("FAIL reset_ctrl: busy=%b done=%b want 0 0", busy, done); end
        total++;
        if ({cen, dec, uni} !== 12'h000)
            begin bad++; $display("FAIL reset_digits: got %h want 000", {cen, dec, uni}); end
        total++;
        if (blank !== 2'b11)
            begin bad++; $display("FAIL reset_blank: got %b want 11", blank); end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_zero;
        int bc, ed;
        logic held, d8, d9;
        convert(8'd0, bc, ed, held, d8, d9);
        total++;
        if (d8 !== 1'b1 || ed !== 0)
            begin bad++; $display("FAIL zero_done: done8=%b early=%0d want 1 0", d8, ed); end
        total++;
        if ({cen, dec, uni} !== 12'h000 || blank !== 2'b11)
            begin bad++; $display("FAIL zero_value: got %h/%b want 000/11", {cen, dec, uni}, blank); end
    endtask

    task automatic test_max;
        int bc, ed;
        logic held, d8, d9;
        convert(8'd255, bc, ed, held, d8, d9);
        total++;
        if (bc !== 8)
            begin bad++; $display("FAIL max_busy_len: got %0d want 8", bc); end
        total++;
        if (d8 !== 1'b1 || ed !== 0 || d9 !== 1'b0)
            begin bad++; $display("FAIL max_done_pulse: got %b%0d%b want 1 0 0", d8, ed, d9); end
        total++;
        if (busy !== 1'b0)
            begin bad++; $display("FAIL max_busy_end: got %b want 0", busy); end
        total++;
        if ({cen, dec, uni} !== 12'h255 || blank !== 2'b00)
            begin bad++; $display("FAIL max_value: got %h/%b want 255/00", {cen, dec, uni}, blank); end
    endtask

    task automatic test_blanking;
        int bc, ed;
        logic held, d8, d9;
        convert(8'd25, bc, ed, held, d8, d9);
        total++;
        if (held !== 1'b1)
            begin bad++; $display("FAIL hold_prev: outputs changed during conversion, got %b want 1", held); end
        total++;
        if ({cen, dec, uni} !== 12'h025 || blank !== 2'b10)
            begin bad++; $display("FAIL v25: got %h/%b want 025/10", {cen, dec, uni}, blank); end
        convert(8'd7, bc, ed, held, d8, d9);
        total++;
        if ({cen, dec, uni} !== 12'h007 || blank !== 2'b11 || d8 !== 1'b1)
            begin bad++; $display("FAIL v7: got %h/%b done=%b want 007/11 1", {cen, dec, uni}, blank, d8); end
    endtask

    task automatic test_back_to_back;
        int v, cyc, last_done, ndone, c, d, u;
        logic [1:0] eb;
        @(negedge clk);
        start     = 1'b1;
        bin       = 8'd0;
        v         = 0;
        cyc       = 0;
        last_done = 0;
        ndone     = 0;
        while (ndone < 256 && cyc < 256 * 9 + 40) begin
            @(negedge clk);
            cyc++;
            if (done === 1'b1) begin
                c  = v / 100;
                d  = (v / 10) % 10;
                u  = v % 10;
                eb = {(c == 0), (c == 0) && (d == 0)};
                total++;
                if (cen !== c[3:0] || dec !== d[3:0] || uni !== u[3:0] || blank !== eb) begin
                    bad++;
                    $display("FAIL sweep_value v=%0d: got %0d%0d%0d/%b want %0d%0d%0d/%b",
                             v, cen, dec, uni, blank, c, d, u, eb);
                end
                total++;
                if (cyc - last_done !== 9)
                    begin bad++; $display("FAIL sweep_period v=%0d: got %0d want 9", v, cyc - last_done); end
                last_done = cyc;
                ndone++;
                v++;
                if (v < 256) bin = v[7:0];
                else start = 1'b0;
            end
        end
        start = 1'b0;
        total++;
        if (ndone !== 256)
            begin bad++; $display("FAIL sweep_count: got %0d want 256", ndone); end
        @(negedge clk);
        @(negedge clk);
        total++;
        if (busy !== 1'b0)
            begin bad++; $display("FAIL sweep_stop: busy got %b want 0", busy); end
    endtask

    task automatic test_ignore_busy;
        int ndone;
        logic stray_busy;
        ndone      = 0;
        stray_busy = 1'b0;
        pulse_start(8'd42);
        for (int k = 0; k < 16; k++) begin
            if (k == 2) begin
                start = 1'b1;
                bin   = 8'd99;
            end else begin
                start = 1'b0;
            end
            if (done === 1'b1) ndone++;
            if (k >= 9 && busy !== 1'b0) stray_busy = 1'b1;
            @(negedge clk);
        end
        total++;
        if (ndone !== 1)
            begin bad++; $display("FAIL ignore_done_cnt: got %0d want 1", ndone); end
        total++;
        if (stray_busy !== 1'b0)
            begin bad++; $display("FAIL ignore_no_queue: got busy after done, want idle"); end
        total++;
        if ({cen, dec, uni} !== 12'h042 || blank !== 2'b10)
            begin bad++; $display("FAIL ignore_value: got %h/%b want 042/10", {cen, dec, uni}, blank); end
    endtask

    task automatic test_reset_mid;
        int bc, ed;
        logic held, d8, d9, seen;
        pulse_start(8'd200);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        total++;
        if (busy !== 1'b1)
            begin bad++; $display("FAIL rstmid_busy_before: got %b want 1", busy); end
        #2;
        rst = 1'b1;
        #1;
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || {cen, dec, uni} !== 12'h000 || blank !== 2'b11)
            begin bad++; $display("FAIL rstmid_immediate: got b%b d%b %h/%b want b0 d0 000/11",
                                  busy, done, {cen, dec, uni}, blank); end
        seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (k == 3) rst = 1'b0;
            if (done !== 1'b0) seen = 1'b1;
        end
        total++;
        if (seen !== 1'b0)
            begin bad++; $display("FAIL rstmid_no_done: got done pulse want none"); end
        convert(8'd137, bc, ed, held, d8, d9);
        total++;
        if ({cen, dec, uni} !== 12'h137 || blank !== 2'b00 || d8 !== 1'b1 || bc !== 8)
            begin bad++; $display("FAIL rstmid_next: got %h/%b done=%b busy=%0d want 137/00 1 8",
                                  {cen, dec, uni}, blank, d8, bc); end
    endtask

    initial begin
        test_reset();
        test_zero();
        test_max();
        test_blanking();
        test_back_to_back();
        test_ignore_busy();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bin_to_bcd_seq.md
BIN_TO_BCD_SEQ -- requirements
Module: bin_to_bcd_seq

Interface
REQ-001 The module SHALL have parameter W, default 8, meaning the binary input width; only W=8 is supported.
REQ-002 The module SHALL have port clk, input, 1, the sole clock; all state updates on the rising edge.
REQ-003 The module SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 The module SHALL have port start, input, 1, request to convert bin; sampled on rising clk.
REQ-005 The module SHALL have port bin, input, 8, unsigned value to convert, e.g. operand sum A+B for the display stage.
REQ-006 The module SHALL have port busy, output, 1, high while a conversion is in progress.
REQ-007 The module SHALL have port done, output, 1, one-cycle pulse marking that the digit outputs have been updated.
REQ-008 The module SHALL have port cen, output, 4, the hundreds BCD digit, 0..2.
REQ-009 The module SHALL have port dec, output, 4, the tens BCD digit, 0..9.
REQ-010 The module SHALL have port uni, output, 4, the units BCD digit, 0..9.
REQ-011 The module SHALL have port blank, output, 2: bit1 means cen is a leading zero, bit0 means dec is a leading zero; the display scanner consumes it.

Function
REQ-012 The block SHALL implement an FSM with states IDLE and SHIFT; in IDLE, busy=0.
REQ-013 In IDLE, start=1 at a rising edge E0 SHALL load bin into an 8-bit shift register, clear the 12-bit BCD scratch register and the 3-bit iteration counter, and move the FSM to SHIFT.
REQ-014 In SHIFT, each of edges E1..E8 SHALL perform one double-dabble iteration: add 3 to every scratch nibble >=5, then shift {scratch, shift register} left by one bit.
REQ-015 At edge E8 the block SHALL copy the final scratch nibbles to cen/dec/uni, update blank, assert done, and return the FSM to IDLE.
REQ-016 Latency SHALL be exactly 8 clocks from the start edge to done high; busy SHALL be high from after E0 until after E8, i.e. 8 cycles.
REQ-017 done SHALL be high for exactly one cycle per conversion, and never outside the cycle following E8.
REQ-018 cen/dec/uni/blank SHALL hold the previous result during a conversion and change only at E8.
REQ-019 start while busy=1 SHALL be ignored; no queuing, and bin changes during SHIFT SHALL have no effect.
REQ-020 If start is high in the cycle where done=1, the FSM is in IDLE and SHALL accept it; start held constantly high yields one conversion every 9 clocks.
REQ-021 blank[1] SHALL equal (cen==0); blank[0] SHALL equal (cen==0 && dec==0); uni SHALL never be blanked.
REQ-022 All arithmetic SHALL be unsigned; for any bin 0..255, the outputs SHALL satisfy cen*100+dec*10+uni == bin, with each digit <=9.

Reset
REQ-023 rst=1 SHALL immediately, without a clock, force FSM=IDLE, busy=0, done=0, cen=dec=uni=0, blank=2'b11, and clear the internal registers and counter.
REQ-024 rst asserted mid-conversion SHALL abort it with no done pulse; after rst release, the first start SHALL behave as in REQ-013.

Verification
REQ-025 The bench SHALL cover: bin=0, start pulse -> after 8 clocks, done=1, cen/dec/uni=0/0/0, blank=11.
REQ-026 The bench SHALL cover: bin=255 -> cen/dec/uni=2/5/5, blank=00, busy high for exactly 8 cycles.
REQ-027 The bench SHALL cover: bin=25 (10+15) -> 0/2/5, blank=10; then bin=7 -> 0/0/7, blank=11.
REQ-028 The bench SHALL cover: start held high, bin stepping 0..255 -> done every 9 clocks; each result matches REQ-022 (exhaustive check).
REQ-029 The bench SHALL cover: start pulsed at busy cycle 3 with a different bin -> ignored; only the first value appears, with a single done.
REQ-030 The bench SHALL cover: rst asserted at busy cycle 4 between edges -> outputs zero immediately with blank=11, no done pulse; the next conversion is correct.
